// File: rtl/mem_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with a one-wait-state bus.
// irq is registered from the committed mtime/mtimecmp values.
module mem_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    localparam logic [1:0] A_MTIME_LO = 2'd0;
    localparam logic [1:0] A_MTIME_HI = 2'd1;
    localparam logic [1:0] A_CMP_LO   = 2'd2;
    localparam logic [1:0] A_CMP_HI   = 2'd3;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    state_e      state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [15:0] presc_q, presc_d;
    logic        irq_q, irq_d;

    logic        is_resp;
    logic        is_wr;
    logic        is_rd;
    logic [31:0] rdata_c;

    // Only address bits [3:2] select a register.
    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:4], mem_addr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    assign is_resp = (state_q == RESP);
    assign is_wr   = is_resp && (wstrb_q != 4'd0);
    assign is_rd   = is_resp && (wstrb_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;
        presc_d    = presc_q;

        unique case (state_q)
            IDLE: begin
                if (mem_valid && enable) begin
                    state_d = RESP;
                    addr_d  = mem_addr[3:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A bus write to mtime wins over the tick and restarts the prescaler.
        if (is_wr && addr_q == A_MTIME_LO) begin
            mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata_q, wstrb_q)};
            presc_d = 16'd0;
        end else if (is_wr && addr_q == A_MTIME_HI) begin
            mtime_d = {merge(mtime_q[63:32], wdata_q, wstrb_q), mtime_q[31:0]};
            presc_d = 16'd0;
        end else if (presc_q == PRESC_MAX) begin
            mtime_d = mtime_q + 64'd1;
            presc_d = 16'd0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        if (is_wr && addr_q == A_CMP_LO)
            mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], wdata_q, wstrb_q);
        if (is_wr && addr_q == A_CMP_HI)
            mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata_q, wstrb_q);

        // Latching the high half on a low read makes lo-then-hi reads coherent.
        if (is_rd && addr_q == A_MTIME_LO)
            shadow_d = mtime_q[63:32];

        irq_d = (mtime_q >= mtimecmp_q);
    end

    always_comb begin
        rdata_c = 32'd0;
        unique case (addr_q)
            A_MTIME_LO: rdata_c = mtime_q[31:0];
            A_MTIME_HI: rdata_c = shadow_q;
            A_CMP_LO:   rdata_c = mtimecmp_q[31:0];
            A_CMP_HI:   rdata_c = mtimecmp_q[63:32];
            default:    rdata_c = 32'd0;
        endcase
    end

    // Reset squashes a response already in flight.
    assign mem_ready = is_resp && !reset;
    assign mem_rdata = mem_ready ? rdata_c : 32'd0;
    assign irq       = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 2'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q   <= 32'd0;
            presc_q    <= 16'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            presc_q    <= presc_d;
            irq_q      <= irq_d;
        end
    end

endmodule
